// File: rtl/uart_tx_buffer_pkg.sv
// rtl/uart_tx_buffer_pkg.sv - drain FSM encodings and hold timing shared by the transmit buffer
`ifndef SD
`define SD
`endif

package uart_tx_buffer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_WAIT = 2'd2
    } drain_state_t;

    // Cycles after the latch pulse during which the UART empty flag is not trusted.
    localparam logic [1:0] HOLD_CYCLES = 2'd2;

endpackage

// File: rtl/tx_fifo_mem.sv
// rtl/tx_fifo_mem.sv - DEPTH x 8 byte storage, synchronous write, asynchronous read
`ifndef SD
`define SD
`endif

module tx_fifo_mem #(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [7:0]        i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [7:0]        o_rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [7:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= `SD i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/uart_tx_buffer.sv
// rtl/uart_tx_buffer.sv - elastic byte buffer draining bus controller characters into the UART
`ifndef SD
`define SD
`endif

module uart_tx_buffer
    import uart_tx_buffer_pkg::*;
#(
    parameter int ADDR_W = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [7:0]      tx_char,
    input  logic            tx_char_valid,
    output logic            tx_char_ready,
    output logic [7:0]      uart_tx_data,
    output logic            uart_tx_latch,
    input  logic            uart_tx_empty,
    output logic [ADDR_W:0] level,
    output logic            overflow,
    input  logic            clr_overflow
);

    localparam logic [ADDR_W:0]   LVL_FULL = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   LVL_ONE  = 1;
    localparam logic [ADDR_W-1:0] PTR_ONE  = 1;

    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_level;
    logic              r_overflow;
    logic [7:0]        r_tx_data;
    logic              r_tx_latch;
    drain_state_t      r_state;
    drain_state_t      w_state_nxt;
    logic [1:0]        r_hold_cnt;
    logic [1:0]        w_hold_cnt_nxt;
    logic              w_pop;
    logic              w_push;
    logic              w_drop;
    logic              w_ready;
    logic [7:0]        w_head;

    // Ready comes from the registered level only, so a pop never frees space in its own cycle.
    assign w_ready = (r_level != LVL_FULL);
    assign w_push  = tx_char_valid & w_ready;
    assign w_drop  = tx_char_valid & ~w_ready;

    tx_fifo_mem #(
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr),
        .i_wdata (tx_char),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_head)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= `SD ST_IDLE;
            r_hold_cnt <= `SD 2'd0;
        end else begin
            r_state    <= `SD w_state_nxt;
            r_hold_cnt <= `SD w_hold_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_hold_cnt_nxt = r_hold_cnt;
        w_pop          = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if ((r_level != '0) && uart_tx_empty) begin
                    w_pop          = 1'b1;
                    w_hold_cnt_nxt = 2'd0;
                    w_state_nxt    = ST_HOLD;
                end
            end
            // The latch cycle itself is the first HOLD cycle; HOLD_CYCLES more follow it.
            ST_HOLD: begin
                if (r_hold_cnt == HOLD_CYCLES) begin
                    w_state_nxt = ST_WAIT;
                end else begin
                    w_hold_cnt_nxt = r_hold_cnt + 2'd1;
                end
            end
            ST_WAIT: begin
                if (uart_tx_empty) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr   <= `SD '0;
            r_rd_ptr   <= `SD '0;
            r_level    <= `SD '0;
            r_overflow <= `SD 1'b0;
            r_tx_data  <= `SD 8'h00;
            r_tx_latch <= `SD 1'b0;
        end else begin
            r_tx_latch <= `SD w_pop;
            if (w_pop) begin
                r_tx_data <= `SD w_head;
                r_rd_ptr  <= `SD r_rd_ptr + PTR_ONE;
            end
            if (w_push) begin
                r_wr_ptr <= `SD r_wr_ptr + PTR_ONE;
            end
            if (w_push && !w_pop) begin
                r_level <= `SD r_level + LVL_ONE;
            end else if (!w_push && w_pop) begin
                r_level <= `SD r_level - LVL_ONE;
            end
            if (w_drop) begin
                r_overflow <= `SD 1'b1;
            end else if (clr_overflow) begin
                r_overflow <= `SD 1'b0;
            end
        end
    end

    assign tx_char_ready = w_ready;
    assign uart_tx_data  = r_tx_data;
    assign uart_tx_latch = r_tx_latch;
    assign level         = r_level;
    assign overflow      = r_overflow;

endmodule

// File: tb/tb_uart_tx_buffer.sv
// tb/tb_uart_tx_buffer.sv - self-checking bench for uart_tx_buffer
module tb_uart_tx_buffer;

    localparam int FRAME = 20;
    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] tx_char;
    logic       tx_char_valid;
    logic       tx_char_ready;
    logic [7:0] uart_tx_data;
    logic       uart_tx_latch;
    logic       uart_tx_empty;
    logic [4:0] level;
    logic       overflow;
    logic       clr_overflow;

    bit force_busy = 1'b0;
    bit uart_busy  = 1'b0;

    assign uart_tx_empty = !force_busy && !uart_busy;

    uart_tx_buffer #(.ADDR_W(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .tx_char       (tx_char),
        .tx_char_valid (tx_char_valid),
        .tx_char_ready (tx_char_ready),
        .uart_tx_data  (uart_tx_data),
        .uart_tx_latch (uart_tx_latch),
        .uart_tx_empty (uart_tx_empty),
        .level         (level),
        .overflow      (overflow),
        .clr_overflow  (clr_overflow)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    // Behavioural model: queue contents, sticky flag, and when the buffer may issue next.
    logic [7:0] q[$];
    int         cyc    = 0;
    bit         m_idle = 1'b1;
    int         m_last = -100;
    bit         m_latch = 1'b0;
    logic [7:0] m_data = 8'h00;
    bit         m_ovf  = 1'b0;
    bit         m_push;

    always @(posedge clk) begin
        if (reset) begin
            q.delete();
            m_idle  = 1'b1;
            m_latch = 1'b0;
            m_data  = 8'h00;
            m_ovf   = 1'b0;
        end else begin
            m_push  = tx_char_valid && (q.size() < DEPTH);
            m_latch = 1'b0;
            if (tx_char_valid && q.size() == DEPTH) m_ovf = 1'b1;
            else if (clr_overflow) m_ovf = 1'b0;
            if (m_idle) begin
                if (q.size() > 0 && uart_tx_empty) begin
                    m_data  = q.pop_front();
                    m_latch = 1'b1;
                    m_idle  = 1'b0;
                    m_last  = cyc + 1;
                end
            end else if (cyc >= m_last + 3 && uart_tx_empty) begin
                m_idle = 1'b1;
            end
            if (m_push) q.push_back(tx_char);
        end
        cyc++;
    end

    // Compare process plus UART model (empty drops 2 cycles after a latch, frame of FRAME cycles).
    int         latch_cnt = 0;
    bit         have_l    = 1'b0;
    int         last_l    = 0;
    int         ff_seen   = 0;
    logic [7:0] obs[$];

    always @(negedge clk) begin
        chk("level", 32'(level), 32'(q.size()));
        chk("ready", 32'(tx_char_ready), 32'(q.size() != DEPTH));
        chk("latch", 32'(uart_tx_latch), 32'(m_latch));
        chk("data", 32'(uart_tx_data), 32'(m_data));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        if (uart_tx_latch) begin
            latch_cnt++;
            obs.push_back(uart_tx_data);
            if (uart_tx_data == 8'hFF) ff_seen++;
            if (have_l) begin
                chk("latch_spacing", 32'(cyc - last_l >= 5), 1);
                chk("latch_while_uart_busy", 32'(cyc >= last_l + 2 + FRAME), 1);
            end
            have_l = 1'b1;
            last_l = cyc;
        end
        uart_busy = have_l && (cyc >= last_l + 2) && (cyc < last_l + 2 + FRAME);
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_obs(input int n, input string nm);
        int k;
        k = 0;
        while (obs.size() < n && k < 800) begin
            tick();
            k++;
        end
        chk(nm, 32'(obs.size() >= n), 1);
    endtask

    int n;
    int k;
    int snap;

    initial begin
        reset         = 1'b1;
        tx_char       = 8'h00;
        tx_char_valid = 1'b0;
        clr_overflow  = 1'b0;
        tick();
        tick();
        chk("rst_level", 32'(level), 0);
        chk("rst_ready", 32'(tx_char_ready), 1);
        chk("rst_latch", 32'(uart_tx_latch), 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_data", 32'(uart_tx_data), 0);
        reset = 1'b0;
        tick();

        tx_char       = 8'hA5;
        tx_char_valid = 1'b1;
        n             = cyc;
        tick();
        tx_char_valid = 1'b0;
        chk("lat_n1_latch", 32'(uart_tx_latch), 0);
        tick();
        chk("lat_n2_latch", 32'(uart_tx_latch), 1);
        chk("lat_n2_data", 32'(uart_tx_data), 32'hA5);
        chk("lat_n2_cycle", 32'(cyc - n), 2);
        repeat (40) tick();

        force_busy = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tx_char       = 8'(i);
            tx_char_valid = 1'b1;
            tick();
        end
        tx_char_valid = 1'b0;
        tick();
        chk("full_level", 32'(level), 16);
        chk("full_ready", 32'(tx_char_ready), 0);
        tx_char       = 8'hFF;
        tx_char_valid = 1'b1;
        tick();
        tx_char_valid = 1'b0;
        chk("ovf_set", 32'(overflow), 1);
        chk("ovf_level", 32'(level), 16);
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        chk("ovf_clr", 32'(overflow), 0);
        obs.delete();
        force_busy = 1'b0;
        wait_obs(16, "drain16_done");
        for (int i = 0; i < 16 && i < obs.size(); i++) chk("order16", 32'(obs[i]), 32'(i));
        repeat (30) tick();

        force_busy = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tx_char       = 8'(8'h40 + i);
            tx_char_valid = 1'b1;
            tick();
        end
        tx_char_valid = 1'b0;
        obs.delete();
        force_busy = 1'b0;
        wait_obs(12, "warmup_done");
        repeat (30) tick();

        force_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tx_char       = 8'(8'hC0 + i);
            tx_char_valid = 1'b1;
            tick();
        end
        tx_char_valid = 1'b0;
        tick();
        chk("pp_pre_level", 32'(level), 3);
        obs.delete();
        force_busy    = 1'b0;
        tx_char       = 8'hC3;
        tx_char_valid = 1'b1;
        tick();
        tx_char_valid = 1'b0;
        chk("pp_level", 32'(level), 3);
        chk("pp_latch", 32'(uart_tx_latch), 1);
        wait_obs(4, "pp_drain_done");
        for (int i = 0; i < 4 && i < obs.size(); i++) chk("pp_order", 32'(obs[i]), 32'(8'hC0 + i));
        repeat (30) tick();

        force_busy = 1'b1;
        for (int i = 0; i < 17; i++) begin
            tx_char       = 8'(8'hD0 + i);
            tx_char_valid = 1'b1;
            tick();
        end
        tx_char_valid = 1'b0;
        chk("mid_ovf", 32'(overflow), 1);
        force_busy = 1'b0;
        k = 0;
        while (!uart_tx_latch && k < 50) begin
            tick();
            k++;
        end
        chk("mid_latch_seen", 32'(uart_tx_latch), 1);
        reset = 1'b1;
        #1;
        chk("mid_rst_latch", 32'(uart_tx_latch), 0);
        chk("mid_rst_level", 32'(level), 0);
        chk("mid_rst_ready", 32'(tx_char_ready), 1);
        chk("mid_rst_overflow", 32'(overflow), 0);
        snap = latch_cnt;
        tick();
        reset = 1'b0;
        repeat (100) tick();
        chk("no_latch_after_reset", 32'(latch_cnt - snap), 0);
        chk("post_rst_level", 32'(level), 0);
        chk("ff_never_sent", 32'(ff_seen), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
